control_mac_fir: RTL
====================

CONTROL_MAC_FIR -- requirements
Module: control_mac_fir

Interface
REQ-001 The module SHALL have parameter Width, default 23, meaning the signed fixed-point word width of samples, coefficients, products and output.
REQ-002 The module SHALL have parameter Presicion, default 14, meaning the number of fractional bits (Q8.14 at default; 1.0 = 16384).
REQ-003 The module SHALL have parameter Taps, default 5, meaning the number of FIR taps and delay-line stages (range 2..16).
REQ-004 clk  input  1  rising-edge system clock, single clock domain.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  new-sample strobe, sampled only in IDLE.
REQ-007 x_in  input  Width  signed input sample, captured on the accepted start edge.
REQ-008 coef_addr  output  $clog2(Taps)  coefficient ROM address (tap index k).
REQ-009 coef_in  input  Width  signed coefficient c[k] from combinational ROM, same cycle as coef_addr.
REQ-010 mult_a  output  Width  signed operand A to the external saturating multiplier.
REQ-011 mult_b  output  Width  signed operand B to the external saturating multiplier.
REQ-012 mult_y  input  Width  signed saturated product from the multiplier, combinational, same cycle.
REQ-013 y_out  output  Width  registered signed filter output.
REQ-014 done  output  1  one-cycle pulse marking a new y_out.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, MAC and DONE.
REQ-017 IDLE with start=1 at a clock edge SHALL go to LOAD, shifting the delay line (d[k] <= d[k-1], d[0] <= x_in), clearing acc to 0 and setting k to 0.
REQ-018 IDLE with start=0 SHALL remain in IDLE with all registers held.
REQ-019 LOAD SHALL go unconditionally to MAC on the next edge.
REQ-020 MAC SHALL last exactly Taps cycles, k = 0..Taps-1, with coef_addr=k, mult_a=d[k] and mult_b=coef_in.
REQ-021 Each MAC edge with k<Taps-1 SHALL perform acc <= sat(acc + mult_y) and k <= k+1.
REQ-022 The MAC edge with k=Taps-1 SHALL load y_out <= sat(acc + mult_y), set done<=1 and go to DONE.
REQ-023 DONE SHALL clear done and go to IDLE on the next edge, so done is high for exactly one cycle.
REQ-024 Latency SHALL be Taps+2 edges from the accepted start edge to the edge that raises done (7 at default).
REQ-025 Outside MAC, mult_a, mult_b and coef_addr SHALL be 0.
REQ-026 sat() SHALL form the Width+1-bit signed sum and clamp it to the range +(2^(Width-1)-1) .. -(2^(Width-1)-1), i.e. 4194303 / -4194303 at default; -2^(Width-1) is never produced.
REQ-027 Saturation SHALL be applied at every accumulate step, not only at the final sum.
REQ-028 start asserted in LOAD, MAC or DONE SHALL be ignored with no queueing; a start held high through DONE is accepted in the following IDLE cycle.
REQ-029 y_out SHALL hold its value between done pulses.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, clear the delay line, acc, k, y_out, done and busy to 0, and drive mult_a, mult_b and coef_addr to 0.
REQ-031 Reset asserted mid-operation SHALL abort the computation with no done pulse and discard the partial acc.
REQ-032 After rst_n rises, the first start SHALL be accepted on the first edge at which it is sampled high in IDLE.

Verification
REQ-033 Impulse: c = {1000, -2000, 3000, 4000, 500}; x_in = 16384 then four starts with x_in=0 -> y_out = 1000, -2000, 3000, 4000, 500 (mult_y = c[k] via the multiplier).
REQ-034 Latency and handshake: a single start pulse -> busy high on the next edge, done high exactly 7 edges after start for one cycle, and busy low one cycle later.
REQ-035 Positive saturation: delay line filled with 4194303 and all c = 16384 -> y_out = 4194303.
REQ-036 Negative saturation: delay line filled with -4194303 and all c = 16384 -> y_out = -4194303 (never -4194304).
REQ-037 Start while busy: start pulsed during MAC cycle 2 -> no extra shift, a single done, and the delay line is unchanged versus the reference model.
REQ-038 Reset mid-MAC: rst_n low during MAC cycle 3 -> outputs are 0 asynchronously, no done, and the next impulse test yields y_out = 1000.

Source files
------------

// File: rtl/control_mac_fir.sv
// Sequential FIR engine: one sample per start, one multiply-accumulate per cycle.
// Drives an external coefficient ROM and saturating multiplier.
module control_mac_fir #(
  parameter int Width     = 23,
  parameter int Presicion = 14,
  parameter int Taps      = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [Width-1:0]  x_in,
  output logic [$clog2(Taps)-1:0]  coef_addr,
  input  logic signed [Width-1:0]  coef_in,
  output logic signed [Width-1:0]  mult_a,
  output logic signed [Width-1:0]  mult_b,
  input  logic signed [Width-1:0]  mult_y,
  output logic signed [Width-1:0]  y_out,
  output logic                     done,
  output logic                     busy
);

  localparam int KW = $clog2(Taps);
  localparam logic [KW-1:0] KLAST = KW'(Taps - 1);

  localparam logic signed [Width:0] SMAX =
    {2'b00, {(Width-1){1'b1}}};
  localparam logic signed [Width:0] SMIN = -SMAX;

  if (Taps < 2 || Taps > 16) begin : g_bad_taps
    $error("control_mac_fir: Taps out of range");
  end
  if (Presicion >= Width) begin : g_bad_prec
    $error("control_mac_fir: Presicion too large");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic signed [Width-1:0] acc_q, acc_d;
  logic signed [Width-1:0] y_q, y_d;
  logic                    done_q, done_d;
  logic signed [Width-1:0] d_q [Taps];
  logic signed [Width-1:0] d_d [Taps];

  logic signed [Width:0]   sum_w;
  logic signed [Width-1:0] sum_sat;
  logic                    in_mac;

  // Width+1 sum cannot overflow; clamp symmetric so -2^(W-1) never appears
  always_comb begin
    sum_w = {acc_q[Width-1], acc_q} + {mult_y[Width-1], mult_y};
    sum_sat = sum_w[Width-1:0];
    unique case (1'b1)
      (sum_w > SMAX): sum_sat = SMAX[Width-1:0];
      (sum_w < SMIN): sum_sat = SMIN[Width-1:0];
      default:        sum_sat = sum_w[Width-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    y_d     = y_q;
    done_d  = 1'b0;
    d_d     = d_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d[0] = x_in;
          for (int i = 1; i < Taps; i++) begin
            d_d[i] = d_q[i-1];
          end
          acc_d   = '0;
          k_d     = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_MAC;
      end
      S_MAC: begin
        if (k_q == KLAST) begin
          y_d     = sum_sat;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          acc_d = sum_sat;
          k_d   = k_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      d_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      done_q  <= done_d;
      d_q     <= d_d;
    end
  end

  // Operand buses are only live during MAC; reset forces IDLE, so they clear at once
  assign in_mac    = (state_q == S_MAC);
  assign coef_addr = in_mac ? k_q      : '0;
  assign mult_a    = in_mac ? d_q[k_q] : '0;
  assign mult_b    = in_mac ? coef_in  : '0;

  assign y_out = y_q;
  assign done  = done_q;
  assign busy  = (state_q != S_IDLE);

endmodule
